icache_dm: RTL and testbench
============================

# icache_dm

Direct-mapped, read-only instruction cache that sits directly downstream of the pipelined datapath's fetch port and upstream of the memory controller. It serves fetch requests from cached frames in the same cycle on a hit. On a miss it runs a single-word fill from memory, then replays the request as a hit. It also keeps hit and miss counters for performance debug.

## Interface
Parameters:
- SETS, 16, number of frames; power of two, minimum 2; IDX = log2(SETS).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset, synchronous, active-low: sampled on the rising edge of CLK.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  the requested word is valid on imemload this cycle.
- imemload  out  32  instruction word; 0 when ihit=0.
- iREN  out  1  memory read request.
- iaddr  out  32  memory read address, word-aligned.
- iwait  in  1  memory busy; the fill word is valid on iload when iwait=0 while iREN=1.
- iload  in  32  memory read data.
- hit_count  out  32  number of cycles with ihit=1; saturates at 32'hFFFF_FFFF.
- miss_count  out  32  number of fills started; saturates at 32'hFFFF_FFFF.

## Operation
- Address split:
  - index = imemaddr[IDX+1:2].
  - tag = imemaddr[31:IDX+2]; tag width is 30−IDX.
- Each frame stores a valid bit, a tag and a 32-bit data word. There is no write path from the datapath.
- Hit is combinational: hit = imemREN & valid[index] & (tag match) & (state==IDLE).
- On a hit: ihit=1 and imemload=data[index].
- FSM states: IDLE, FETCH.
  - IDLE, imemREN=1 and miss: latch {tag,index} into miss_addr, increment miss_count, go to FETCH.
  - IDLE, hit or imemREN=0: stay in IDLE.
  - FETCH: drive iREN=1 and iaddr={miss_addr,2'b00}. ihit is held at 0.
  - FETCH, iwait=1: stay in FETCH.
  - FETCH, iwait=0: write iload into frame miss_addr.index, set its valid bit, store its tag, go to IDLE.
- A fill always completes once started. It completes even if imemREN drops or imemaddr changes during FETCH (PC redirect on branch/jump flush). After the fill, the new imemaddr is evaluated in IDLE.
- When a fill targets a frame that already holds a valid tag, the frame is overwritten (conflict eviction).
- In IDLE: iREN=0 and iaddr={miss_addr,2'b00}.
- Counters:
  - hit_count increments on every cycle with ihit=1, including repeated hits while the datapath is stalled on dhit.
  - Both counters saturate; they never wrap.

## Timing
- Reset (nRST=0 at an edge):
  - State goes to IDLE; all valid bits, miss_addr and both counters are cleared.
  - Data and tag arrays need no reset.
  - Outputs after the edge: ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0.
- Reset asserted in FETCH aborts the fill: no frame is written, and iREN is 0 in the cycle after the reset edge.
- Hit latency is 0 cycles: ihit is asserted in the same cycle as imemREN and address.
- Miss penalty, with memory returning after W cycles of iwait=1:
  - cycle 0: miss detected in IDLE.
  - cycles 1..W+1: FETCH, with iwait=0 in the last of these.
  - cycle W+2: IDLE, ihit=1.
  - Minimum penalty is 2 cycles (W=0).
- iREN and iaddr come only from registered state: they are stable for the whole FETCH and free of imemaddr glitches.
- A fill and a hit never occur in the same cycle.

## Test plan
- Reset, then imemREN=1, imemaddr=0x0000_0000, iwait=0 for one FETCH cycle, iload=0x2001_0005:
  - ihit=0 in cycle 0.
  - iREN=1 with iaddr=0 in cycle 1.
  - ihit=1 and imemload=0x2001_0005 in cycle 2.
  - miss_count=1.
- Repeat the fetch of 0x0 for 5 cycles: ihit=1 every cycle, iREN=0, hit_count increases by 5.
- Conflict with SETS=16: fill 0x0000_0004, then fetch 0x0000_0044 (same index 1, different tag):
  - 0x44 misses and refills frame 1.
  - A later fetch of 0x4 misses again; miss_count=3.
- Hold iwait=1 for 4 cycles in FETCH while imemaddr changes 0x10→0x80:
  - iaddr stays 0x10 throughout.
  - After the fill, frame 4 holds the 0x10 data.
  - 0x80 then misses; ihit stays 0 until its own fill completes.
- Assert nRST=0 for one edge while in FETCH:
  - iREN=0 the next cycle; miss_count=0.
  - The previously valid address 0x0 misses (all valid bits were cleared).
- Force hit_count to 32'hFFFF_FFFE through a preload hook, then run 3 hit cycles: the count holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side bus of the direct-mapped instruction cache.
//   master : environment (datapath fetch port + memory controller + debug hooks)
//   slave  : the cache
// Signals:
//   imemREN/imemaddr -> fetch request        ihit/imemload <- fetch response
//   iREN/iaddr       <- memory read request  iwait/iload   -> memory response
//   hit_count/miss_count <- perf counters    hc_load/hc_load_val -> hit_count preload hook
interface icache_dm_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        hc_load;
  logic [31:0] hc_load_val;

  modport master (
    output imemREN, imemaddr, iwait, iload, hc_load, hc_load_val,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport slave (
    input  imemREN, imemaddr, iwait, iload, hc_load, hc_load_val,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with single-word fills.
// Hits are served combinationally in IDLE; a miss latches the word address,
// runs one memory read in FETCH, writes the frame, then returns to IDLE where
// the request replays as a hit. Saturating hit/miss counters for debug.
// Ports:
//   CLK  : clock
//   nRST : synchronous active-low reset
//   bus  : icache_dm_if.slave (fetch port, memory port, counters, preload hook)
module icache_dm #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_dm_if.slave  bus
);

  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TW  = 30 - IDX;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_q;
  logic [SETS-1:0]   valid_q;
  logic [TW-1:0]     tag_q  [SETS];
  logic [31:0]       data_q [SETS];
  logic [29:0]       miss_addr_q;
  logic [31:0]       hit_cnt_q,  hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]    req_idx;
  logic [TW-1:0]     req_tag;
  logic [IDX-1:0]    fill_idx;
  logic              hit;
  logic              miss_start;
  logic              fill_done;
  logic              unused_addr_bits;

  assign req_idx  = bus.imemaddr[IDX+1:2];
  assign req_tag  = bus.imemaddr[31:IDX+2];
  assign fill_idx = miss_addr_q[IDX-1:0];
  assign unused_addr_bits = ^bus.imemaddr[1:0];

  assign hit        = bus.imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                      && (state_q == IDLE);
  assign miss_start = (state_q == IDLE) && bus.imemREN && !hit;
  assign fill_done  = (state_q == FETCH) && !bus.iwait;

  assign bus.ihit       = hit;
  assign bus.imemload   = hit ? data_q[req_idx] : 32'h0;
  // Memory side depends only on registered state, so it cannot glitch with imemaddr.
  assign bus.iREN       = (state_q == FETCH);
  assign bus.iaddr      = {miss_addr_q, 2'b00};
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

  // Saturating counters; preload hook overrides the hit counter for that cycle.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.hc_load) begin
      hit_cnt_d = bus.hc_load_val;
    end else if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Control state, valid bits and counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            miss_addr_q <= {req_tag, req_idx};
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (!bus.iwait) begin
            valid_q[fill_idx] <= 1'b1;
            state_q           <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; a reset edge during FETCH suppresses the write.
  always_ff @(posedge CLK) begin
    if (nRST && fill_done) begin
      tag_q[fill_idx]  <= miss_addr_q[29:IDX];
      data_q[fill_idx] <= bus.iload;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Randomized and directed bench for icache_dm against a behavioural cache model.
module tb_icache_dm;

  logic clk;
  logic nrst;
  int   total;
  int   bad;

  icache_dm_if bif();

  icache_dm #(.SETS(16)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: each frame remembers which word address it holds.
  bit          m_valid [16];
  logic [29:0] m_line  [16];
  bit          m_filling;
  logic [29:0] m_pending;
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  // Last observed outputs, for directed constant checks.
  logic        o_ihit;
  logic [31:0] o_load;
  logic        o_iren;
  logic [31:0] o_iaddr;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    return (32'(wa) * 32'h9E37_79B1) ^ 32'h2001_0005;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, advance model at posedge.
  task automatic cycle(input logic rst, input logic req, input logic [31:0] addr,
                       input logic wt, input logic hcl, input logic [31:0] hcv);
    logic        e_hit;
    logic [3:0]  fr;
    logic [29:0] wa;
    nrst             = ~rst;
    bif.imemREN      = req;
    bif.imemaddr     = addr;
    bif.iwait        = wt;
    bif.hc_load      = hcl;
    bif.hc_load_val  = hcv;
    bif.iload        = m_filling ? mem_word(m_pending) : $urandom;
    wa = addr[31:2];
    fr = addr[5:2];
    e_hit = !m_filling && req && m_valid[fr] && (m_line[fr] == wa);
    @(negedge clk);
    o_ihit  = bif.ihit;
    o_load  = bif.imemload;
    o_iren  = bif.iREN;
    o_iaddr = bif.iaddr;
    check("ihit",       32'(bif.ihit), 32'(e_hit));
    check("imemload",   bif.imemload, e_hit ? mem_word(m_line[fr]) : 32'h0);
    check("iREN",       32'(bif.iREN), 32'(m_filling));
    check("iaddr",      bif.iaddr, {m_pending, 2'b00});
    check("hit_count",  bif.hit_count, m_hits);
    check("miss_count", bif.miss_count, m_misses);
    @(posedge clk);
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_filling = 1'b0;
      m_pending = '0;
      m_hits    = '0;
      m_misses  = '0;
    end else begin
      if (hcl) m_hits = hcv;
      else if (e_hit && m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
      if (m_filling) begin
        if (!wt) begin
          m_valid[m_pending[3:0]] = 1'b1;
          m_line[m_pending[3:0]]  = m_pending;
          m_filling = 1'b0;
        end
      end else if (req && !e_hit) begin
        m_pending = wa;
        m_filling = 1'b1;
        if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
      end
    end
    #1;
  endtask

  task automatic run(input logic req, input logic [31:0] addr, input logic wt);
    cycle(1'b0, req, addr, wt, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    foreach (m_line[i])  m_line[i]  = '0;
    m_filling = 1'b0;
    m_pending = '0;
    m_hits    = '0;
    m_misses  = '0;
    nrst = 1'b0;
    bif.imemREN = 1'b0; bif.imemaddr = '0; bif.iwait = 1'b0;
    bif.iload = '0; bif.hc_load = 1'b0; bif.hc_load_val = '0;
    @(posedge clk); #1;
    do_reset();
    check("rst_ihit",  32'(bif.ihit), 32'h0);
    check("rst_iren",  32'(bif.iREN), 32'h0);
    check("rst_iaddr", bif.iaddr, 32'h0);
    check("rst_miss",  bif.miss_count, 32'h0);
    check("rst_hits",  bif.hit_count, 32'h0);

    // First fetch of 0x0: miss, one FETCH cycle, then hit.
    run(1'b1, 32'h0, 1'b0);
    check("c0_ihit", 32'(o_ihit), 32'h0);
    run(1'b1, 32'h0, 1'b0);
    check("c1_iren",  32'(o_iren), 32'h1);
    check("c1_iaddr", o_iaddr, 32'h0);
    run(1'b1, 32'h0, 1'b0);
    check("c2_ihit", 32'(o_ihit), 32'h1);
    check("c2_load", o_load, 32'h2001_0005);
    check("miss_one", bif.miss_count, 32'h1);
    for (int i = 0; i < 5; i++) run(1'b1, 32'h0, 1'b0);
    check("hits_six", bif.hit_count, 32'h6);

    // Conflict eviction on frame 1 from a fresh reset.
    do_reset();
    run(1'b1, 32'h4, 1'b0); run(1'b1, 32'h4, 1'b0); run(1'b1, 32'h4, 1'b0);
    run(1'b1, 32'h44, 1'b0);
    check("conf_miss44", 32'(o_ihit), 32'h0);
    run(1'b1, 32'h44, 1'b0); run(1'b1, 32'h44, 1'b0);
    check("conf_hit44", 32'(o_ihit), 32'h1);
    run(1'b1, 32'h4, 1'b0);
    check("conf_miss4", 32'(o_ihit), 32'h0);
    run(1'b1, 32'h4, 1'b1);
    check("conf_count", bif.miss_count, 32'h3);
    run(1'b1, 32'h4, 1'b0);

    // Long fill with PC redirect mid-fill.
    run(1'b1, 32'h10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run(1'b1, 32'h80, 1'b1);
      check("redir_iaddr", o_iaddr, 32'h10);
    end
    run(1'b1, 32'h80, 1'b0);
    check("redir_fill_noh", 32'(o_ihit), 32'h0);
    run(1'b1, 32'h80, 1'b0);
    check("redir_80_miss", 32'(o_ihit), 32'h0);
    run(1'b1, 32'h80, 1'b0);
    run(1'b1, 32'h80, 1'b0);
    check("redir_80_hit", 32'(o_ihit), 32'h1);
    run(1'b1, 32'h10, 1'b0);
    check("frame4_hit", 32'(o_ihit), 32'h1);
    check("frame4_load", o_load, mem_word(30'h4));

    // Reset during FETCH aborts the fill and drops all valid bits.
    run(1'b1, 32'h0, 1'b0);
    run(1'b1, 32'h0, 1'b0);
    run(1'b1, 32'h24, 1'b0);
    do_reset();
    check("abort_iren", 32'(bif.iREN), 32'h0);
    check("abort_miss", bif.miss_count, 32'h0);
    run(1'b1, 32'h0, 1'b1);
    check("abort_0miss", 32'(o_ihit), 32'h0);
    run(1'b1, 32'h0, 1'b0);
    run(1'b1, 32'h0, 1'b0);

    // Hit counter saturation via preload hook.
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) run(1'b1, 32'h0, 1'b0);
    check("hc_sat", bif.hit_count, 32'hFFFF_FFFF);

    // Random traffic over a small address pool to mix hits, misses and conflicts.
    for (int n = 0; n < 3000; n++) begin
      logic rst_r, req_r, wt_r, hcl_r;
      logic [31:0] a;
      rst_r = ($urandom_range(0, 199) == 0);
      hcl_r = ($urandom_range(0, 499) == 0);
      req_r = ($urandom_range(0, 9) < 8);
      wt_r  = ($urandom_range(0, 9) < 4);
      a     = {$urandom_range(0, 63), 2'($urandom_range(0, 3))} & 32'h0000_00FF;
      cycle(rst_r, req_r, a, wt_r, hcl_r, 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
